taxel_frame_capture: RTL and testbench

//  Consumes ADC conversion results taken while the switch/read mux selects scan the taxel array.

---
 rtl/taxel_frame_capture.sv | 132 +++++++++++++
 tb/tb_taxel_frame_capture.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/taxel_frame_capture.sv
// rtl/taxel_frame_capture.sv - taxel scan capture: per-taxel oversample averaging into a ping-pong frame buffer
// A frame is accepted only as an unbroken 0..N-1 scan; any break drops back to SYNC and waits for taxel 0.
module taxel_frame_capture #(
  parameter int SW_WIRE_CNT     = 16,
  parameter int RD_WIRE_CNT     = 16,
  parameter int SEL_WIDTH       = 5,
  parameter int ADC_WIDTH       = 12,
  parameter int OVERSAMPLE_LOG2 = 2,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                                             clk_ref,
  input  logic                                             rst_n,
  input  logic                                             adc_valid,
  input  logic [ADC_WIDTH-1:0]                             adc_data,
  input  logic [SEL_WIDTH-1:0]                             sw_mux_sel,
  input  logic [SEL_WIDTH-1:0]                             rd_mux_sel,
  input  logic                                             rd_req,
  input  logic [$clog2(SW_WIRE_CNT*RD_WIRE_CNT)-1:0]       rd_addr,
  input  logic                                             err_clr,
  output logic [ADC_WIDTH-1:0]                             rd_data,
  output logic                                             rd_valid,
  output logic                                             bank_sel,
  output logic                                             frame_ready,
  output logic [FRAME_CNT_WIDTH-1:0]                       frame_count,
  output logic                                             seq_err,
  output logic                                             range_err
);

  localparam int N     = SW_WIRE_CNT * RD_WIRE_CNT;
  localparam int IDX_W = $clog2(N);
  localparam int AW    = ADC_WIDTH + OVERSAMPLE_LOG2;
  localparam int CW    = OVERSAMPLE_LOG2 + 1;
  localparam int K     = 1 << OVERSAMPLE_LOG2;

  typedef enum logic {SYNC, CAPTURE} state_t;

  state_t           state, state_next;
  logic [AW-1:0]    acc, acc_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [IDX_W-1:0] exp_idx, exp_next;
  logic             wr_en, swap, seq_set, range_set;

  logic [ADC_WIDTH-1:0] mem [0:1][0:N-1];

  logic             in_range, sample, hit, last_sample, last_taxel;
  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    sum;
  logic [CW-1:0]    cnt_inc;
  logic [ADC_WIDTH-1:0] avg;

  assign in_range    = (32'(sw_mux_sel) < SW_WIRE_CNT) && (32'(rd_mux_sel) < RD_WIRE_CNT);
  assign idx         = IDX_W'(sw_mux_sel) * IDX_W'(RD_WIRE_CNT) + IDX_W'(rd_mux_sel);
  assign sample      = adc_valid && in_range;
  // While mid-average exp_idx holds the taxel being averaged, so one compare covers both cases.
  assign hit         = (state == SYNC) ? (idx == '0) : (idx == exp_idx);
  assign sum         = acc + AW'(adc_data);
  assign cnt_inc     = cnt + 1'b1;
  assign last_sample = (cnt_inc == CW'(K));
  assign last_taxel  = (idx == IDX_W'(N - 1));
  assign avg         = ADC_WIDTH'(sum >> OVERSAMPLE_LOG2);
  assign range_set   = adc_valid && !in_range;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (sample) state_next = hit ? CAPTURE : SYNC;
  end

  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    exp_next = exp_idx;
    wr_en    = 1'b0;
    swap     = 1'b0;
    seq_set  = 1'b0;
    if (sample) begin
      if (hit) begin
        if (last_sample) begin
          wr_en    = 1'b1;
          acc_next = '0;
          cnt_next = '0;
          exp_next = last_taxel ? '0 : idx + 1'b1;
          swap     = last_taxel;
        end else begin
          acc_next = sum;
          cnt_next = cnt_inc;
        end
      end else if (state == CAPTURE) begin
        seq_set  = 1'b1;
        acc_next = '0;
        cnt_next = '0;
        exp_next = '0;
      end
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cnt         <= '0;
      exp_idx     <= '0;
      bank_sel    <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      seq_err     <= 1'b0;
      range_err   <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      acc         <= acc_next;
      cnt         <= cnt_next;
      exp_idx     <= exp_next;
      bank_sel    <= bank_sel ^ swap;
      frame_ready <= swap;
      frame_count <= frame_count + FRAME_CNT_WIDTH'(swap);
      seq_err     <= seq_set | (seq_err & ~err_clr);
      range_err   <= range_set | (range_err & ~err_clr);
      rd_valid    <= rd_req;
      if (rd_req) rd_data <= (32'(rd_addr) < N) ? mem[bank_sel][rd_addr] : '0;
    end
  end

  // Buffer contents are deliberately left unreset so the array can map onto plain RAM.
  always_ff @(posedge clk_ref) begin
    if (wr_en) mem[!bank_sel][idx] <= avg;
  end

endmodule

// File: tb/tb_taxel_frame_capture.sv
// tb/tb_taxel_frame_capture.sv - directed self-checking bench for taxel_frame_capture
module tb_taxel_frame_capture;

  logic        clk_ref = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic [4:0]  sw_mux_sel = '0;
  logic [4:0]  rd_mux_sel = '0;
  logic        rd_req = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic        err_clr = 1'b0;
  logic [11:0] rd_data;
  logic        rd_valid, bank_sel, frame_ready, seq_err, range_err;
  logic [15:0] frame_count;

  logic        s_rd_req = 1'b0;
  logic [3:0]  s_rd_addr = '0;
  logic [11:0] s_rd_data;
  logic        s_rd_valid, s_bank_sel, s_frame_ready, s_seq_err, s_range_err;
  logic [15:0] s_frame_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_ref = ~clk_ref;

  taxel_frame_capture dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .sw_mux_sel(sw_mux_sel), .rd_mux_sel(rd_mux_sel), .rd_req(rd_req), .rd_addr(rd_addr),
    .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid), .bank_sel(bank_sel),
    .frame_ready(frame_ready), .frame_count(frame_count), .seq_err(seq_err), .range_err(range_err)
  );

  // 3x5 array: N=15 is not a power of two, so rd_addr=15 is a reachable out-of-range address.
  taxel_frame_capture #(.SW_WIRE_CNT(3), .RD_WIRE_CNT(5)) dut_small (
    .clk_ref(clk_ref), .rst_n(rst_n), .adc_valid(1'b0), .adc_data(12'd0),
    .sw_mux_sel(5'd0), .rd_mux_sel(5'd0), .rd_req(s_rd_req), .rd_addr(s_rd_addr),
    .err_clr(1'b0), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .bank_sel(s_bank_sel),
    .frame_ready(s_frame_ready), .frame_count(s_frame_count), .seq_err(s_seq_err), .range_err(s_range_err)
  );

  task automatic send_raw(input int s, input int r, input int d);
    adc_valid  = 1'b1;
    sw_mux_sel = 5'(s);
    rd_mux_sel = 5'(r);
    adc_data   = 12'(d);
    @(negedge clk_ref);
    adc_valid  = 1'b0;
  endtask

  task automatic send_idx(input int k, input int d);
    send_raw(k / 16, k % 16, d);
  endtask

  function automatic int sval(input int mode, input int v, input int k, input int j);
    if (mode == 0) return (j == 3) ? k + 3 : k;
    if (mode == 1) return v;
    return k + v;
  endfunction

  task automatic send_frame(input int mode, input int v);
    for (int k = 0; k < 256; k++)
      for (int j = 0; j < 4; j++) send_idx(k, sval(mode, v, k, j));
  endtask

  task automatic do_read(input int a, output logic [11:0] d, output logic v);
    rd_req  = 1'b1;
    rd_addr = 8'(a);
    @(negedge clk_ref);
    rd_req  = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) send_idx(k, 9);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd_data !== 12'd0 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %0d/%0b want 0/0", rd_data, rd_valid); end
    checks++; if (bank_sel !== 1'b0 || frame_ready !== 1'b0) begin errors++; $display("FAIL reset_bank got %0b/%0b want 0/0", bank_sel, frame_ready); end
    checks++; if (frame_count !== 16'd0 || seq_err !== 1'b0 || range_err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got %0d/%0b/%0b want 0/0/0", frame_count, seq_err, range_err); end
    @(negedge clk_ref);
    rst_n = 1'b1;
    @(negedge clk_ref);
    for (int k = 5; k < 8; k++)
      for (int j = 0; j < 4; j++) send_idx(k, 1000);
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL sync_ignore seq_err got %0b want 0", seq_err); end
  endtask

  task automatic test_full_frame();
    logic [11:0] d;
    logic v;
    send_frame(0, 0);
    checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL full_ready got %0b want 1", frame_ready); end
    checks++; if (bank_sel !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL full_bank_cnt got %0b/%0d want 1/1", bank_sel, frame_count); end
    @(negedge clk_ref);
    checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pulse got %0b want 0", frame_ready); end
    do_read(37, d, v);
    checks++; if (d !== 12'd37 || v !== 1'b1) begin errors++; $display("FAIL read37 got %0d/%0b want 37/1", d, v); end
    do_read(255, d, v);
    checks++; if (d !== 12'd255 || v !== 1'b1) begin errors++; $display("FAIL read255 got %0d/%0b want 255/1", d, v); end
    @(negedge clk_ref);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_idle got %0b want 0", rd_valid); end
  endtask

  task automatic test_seq_err();
    logic [11:0] d;
    logic v;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++) send_idx(k, 50);
    send_idx(11, 50);
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_set got %0b want 1", seq_err); end
    for (int k = 11; k < 21; k++)
      for (int j = 0; j < 4; j++) send_idx(k, 50);
    checks++; if (frame_count !== 16'd1 || bank_sel !== 1'b1) begin errors++; $display("FAIL seq_no_frame got %0d/%0b want 1/1", frame_count, bank_sel); end
    err_clr = 1'b1;
    @(negedge clk_ref);
    err_clr = 1'b0;
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clr got %0b want 0", seq_err); end
    send_frame(2, 500);
    checks++; if (frame_ready !== 1'b1 || frame_count !== 16'd2 || bank_sel !== 1'b0) begin errors++; $display("FAIL resync_frame got %0b/%0d/%0b want 1/2/0", frame_ready, frame_count, bank_sel); end
    do_read(10, d, v);
    checks++; if (d !== 12'd510) begin errors++; $display("FAIL resync_read10 got %0d want 510", d); end
  endtask

  task automatic test_range_err();
    logic [11:0] d;
    logic v;
    for (int k = 0; k < 256; k++) begin
      if (k == 51) begin
        send_raw(16, 0, 77);
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_set got %0b want 1", range_err); end
      end
      for (int j = 0; j < 4; j++) send_idx(k, 300);
    end
    checks++; if (frame_count !== 16'd3 || bank_sel !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL range_frame got %0d/%0b/%0b want 3/1/0", frame_count, bank_sel, seq_err); end
    do_read(51, d, v);
    checks++; if (d !== 12'd300) begin errors++; $display("FAIL range_read51 got %0d want 300", d); end
    err_clr = 1'b1;
    @(negedge clk_ref);
    err_clr = 1'b0;
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL range_clr got %0b want 0", range_err); end
  endtask

  task automatic test_ping_pong();
    logic [11:0] d;
    logic v;
    send_frame(1, 100);
    checks++; if (frame_count !== 16'd4 || bank_sel !== 1'b0) begin errors++; $display("FAIL pp_frame1 got %0d/%0b want 4/0", frame_count, bank_sel); end
    for (int k = 0; k < 255; k++) begin
      for (int j = 0; j < 4; j++) send_idx(k, 200);
      if (k == 128) begin
        do_read(0, d, v);
        checks++; if (d !== 12'd100) begin errors++; $display("FAIL pp_mid_read got %0d want 100", d); end
      end
    end
    for (int j = 0; j < 3; j++) send_idx(255, 200);
    adc_valid = 1'b1; sw_mux_sel = 5'd15; rd_mux_sel = 5'd15; adc_data = 12'd200;
    rd_req = 1'b1; rd_addr = 8'd0;
    @(negedge clk_ref);
    adc_valid = 1'b0; rd_req = 1'b0;
    checks++; if (rd_data !== 12'd100 || rd_valid !== 1'b1) begin errors++; $display("FAIL pp_swap_read got %0d/%0b want 100/1", rd_data, rd_valid); end
    checks++; if (frame_ready !== 1'b1 || bank_sel !== 1'b1 || frame_count !== 16'd5) begin errors++; $display("FAIL pp_swap got %0b/%0b/%0d want 1/1/5", frame_ready, bank_sel, frame_count); end
    do_read(0, d, v);
    checks++; if (d !== 12'd200) begin errors++; $display("FAIL pp_after_read got %0d want 200", d); end
  endtask

  task automatic test_full_scale();
    logic [11:0] d;
    logic v;
    send_frame(1, 4095);
    checks++; if (frame_count !== 16'd6) begin errors++; $display("FAIL fs_count got %0d want 6", frame_count); end
    for (int a = 0; a < 256; a += 85) begin
      do_read(a, d, v);
      checks++; if (d !== 12'd4095 || v !== 1'b1) begin errors++; $display("FAIL fs_read%0d got %0d/%0b want 4095/1", a, d, v); end
    end
    s_rd_req = 1'b1; s_rd_addr = 4'd15;
    @(negedge clk_ref);
    s_rd_req = 1'b0;
    checks++; if (s_rd_data !== 12'd0 || s_rd_valid !== 1'b1) begin errors++; $display("FAIL oor_read got %0d/%0b want 0/1", s_rd_data, s_rd_valid); end
  endtask

  initial begin
    repeat (3) @(negedge clk_ref);
    rst_n = 1'b1;
    @(negedge clk_ref);
    test_reset();
    test_full_frame();
    test_seq_err();
    test_range_err();
    test_ping_pong();
    test_full_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
